// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end sequencer: op codes, FSM states and
// the multiply cycle count of the shift-add/Booth ALU.
package alu_pkg;

    localparam int MULT_CYCLES = 18;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ALIGN   = 3'd1,
        EXEC    = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } seq_state_t;

endpackage

// File: rtl/alu_sequencer_phase_tracker.sv
// Shadow copy of the ALU's internal step counter: advances on every enabled
// ALU cycle and wraps at MOD, so the sequencer knows how far a multiply is from phase 0.
module alu_phase_tracker #(
    parameter int MOD = 18,
    parameter int W   = 5
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         enable,
    output logic [W-1:0] phase,
    output logic [W:0]   cycles_to_zero
);

    localparam logic [W-1:0] PHASE_LAST = W'(MOD - 1);
    localparam logic [W:0]   PHASE_MOD  = (W + 1)'(MOD);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase <= '0;
        end else if (enable) begin
            phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
        end
    end

    // Enabled cycles still needed to bring the ALU counter back to 0.
    assign cycles_to_zero = PHASE_MOD - {1'b0, phase};

endmodule

// File: rtl/alu_sequencer.sv
// Single-outstanding front end for the shift-add/Booth ALU: accepts a request,
// aligns the ALU phase for multiplies, runs the operation and returns the result.
module alu_sequencer #(
    parameter int WIDTH       = 16,
    parameter int MULT_CYCLES = alu_pkg::MULT_CYCLES,
    parameter int PHASE_W     = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_error,
    output logic             busy,
    output logic [WIDTH-1:0] alu_operand_1,
    output logic [WIDTH-1:0] alu_operand_2,
    output logic             alu_enable,
    output logic [1:0]       alu_op_select,
    input  logic [WIDTH-1:0] alu_result
);

    import alu_pkg::*;

    localparam logic [PHASE_W:0] STEP_ONE = (PHASE_W + 1)'(1);
    localparam logic [PHASE_W:0] STEP_MUL = (PHASE_W + 1)'(MULT_CYCLES);

    seq_state_t         state;
    logic [PHASE_W:0]   step;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W:0]   cycles_to_zero;

    alu_phase_tracker #(
        .MOD (MULT_CYCLES),
        .W   (PHASE_W)
    ) u_phase (
        .clock          (clock),
        .reset_n        (reset_n),
        .enable         (alu_enable),
        .phase          (phase),
        .cycles_to_zero (cycles_to_zero)
    );

    // Request handshake: a transfer happens on a rising edge where req_valid
    // and req_ready are both high; response likewise with rsp_valid/rsp_ready.
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            step          <= '0;
            op_q          <= OP_ADD;
            a_q           <= '0;
            b_q           <= '0;
            rsp_valid     <= 1'b0;
            rsp_error     <= 1'b0;
            rsp_result    <= '0;
            alu_enable    <= 1'b0;
            alu_op_select <= OP_ADD;
            alu_operand_1 <= '0;
            alu_operand_2 <= '0;
        end else begin
            // ALU drive is registered from the current state; ALIGN issues
            // add-of-zero cycles purely to advance the ALU counter.
            alu_enable    <= (state == ALIGN) || (state == EXEC);
            alu_op_select <= (state == EXEC) ? op_q : OP_ADD;
            alu_operand_1 <= (state == EXEC) ? a_q : '0;
            alu_operand_2 <= (state == EXEC) ? b_q : '0;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q <= req_op;
                        a_q  <= req_a;
                        b_q  <= req_b;
                        if (req_op == OP_RSV) begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_error  <= 1'b1;
                            rsp_result <= '0;
                        end else if (req_op != OP_MUL) begin
                            state <= EXEC;
                            step  <= STEP_ONE;
                        end else if (phase == '0) begin
                            state <= EXEC;
                            step  <= STEP_MUL;
                        end else begin
                            state <= ALIGN;
                            step  <= cycles_to_zero;
                        end
                    end
                end
                ALIGN: begin
                    if (step == STEP_ONE) begin
                        state <= EXEC;
                        step  <= STEP_MUL;
                    end else begin
                        step <= step - 1'b1;
                    end
                end
                EXEC: begin
                    step <= step - 1'b1;
                    if (step == STEP_ONE) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // Wait for the last registered enable to retire so the
                    // ALU result register holds the final value.
                    if (!alu_enable) begin
                        rsp_result <= alu_result;
                        rsp_valid  <= 1'b1;
                        rsp_error  <= 1'b0;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised scoreboard bench for alu_sequencer with a behavioural ALU attached
// to its drive port and an arithmetic reference model for results and timing.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = 2'b00;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_error;
    logic         busy;
    logic [W-1:0] alu_operand_1;
    logic [W-1:0] alu_operand_2;
    logic         alu_enable;
    logic [1:0]   alu_op_select;
    logic [W-1:0] alu_result;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ref_phase = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_err_q[$];
    int           exp_cyc_q[$];
    int           exp_en_q[$];

    logic bp_mode = 1'b0;
    logic bp_rand = 1'b1;
    logic rdy_hold = 1'b1;
    assign rsp_ready = bp_mode ? bp_rand : rdy_hold;

    alu_sequencer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_a         (req_a),
        .req_b         (req_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_error     (rsp_error),
        .busy          (busy),
        .alu_operand_1 (alu_operand_1),
        .alu_operand_2 (alu_operand_2),
        .alu_enable    (alu_enable),
        .alu_op_select (alu_op_select),
        .alu_result    (alu_result)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural ALU ----------------
    // 18-step counter advancing on enable; add/sub update the result each
    // enabled cycle, a multiply latches operands at step 0 and writes at step 17.
    int           alu_cnt;
    logic [W-1:0] ma, mb;
    logic         prev_mul;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_cnt    <= 0;
            alu_result <= '0;
            prev_mul   <= 1'b0;
            ma         <= '0;
            mb         <= '0;
        end else if (alu_enable) begin
            alu_cnt  <= (alu_cnt + 1) % MULT_CYCLES;
            prev_mul <= (alu_op_select == OP_MUL);
            if (alu_op_select == OP_MUL && !prev_mul) check("mul_start_phase", alu_cnt, 0);
            case (alu_op_select)
                OP_ADD: alu_result <= alu_operand_1 + alu_operand_2;
                OP_SUB: alu_result <= alu_operand_1 - alu_operand_2;
                OP_MUL: begin
                    if (alu_cnt == 0) begin
                        ma <= alu_operand_1;
                        mb <= alu_operand_2;
                    end
                    if (alu_cnt == MULT_CYCLES - 1) alu_result <= ma * mb;
                end
                default: ;
            endcase
        end else begin
            prev_mul <= 1'b0;
        end
    end

    // ---------------- reference model ----------------
    task automatic push_exp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int accept_cyc);
        logic [W-1:0] r;
        logic         e;
        int           lat, en;
        e = 1'b0;
        case (op)
            OP_ADD: begin r = a + b; lat = 3; en = 1; ref_phase = (ref_phase + 1) % MULT_CYCLES; end
            OP_SUB: begin r = a - b; lat = 3; en = 1; ref_phase = (ref_phase + 1) % MULT_CYCLES; end
            OP_MUL: begin
                r   = a * b;
                en  = (ref_phase == 0) ? MULT_CYCLES : 2 * MULT_CYCLES - ref_phase;
                lat = en + 2;
                ref_phase = 0;
            end
            default: begin r = '0; e = 1'b1; lat = 0; en = 0; end
        endcase
        exp_q.push_back(r);
        exp_err_q.push_back(e);
        exp_cyc_q.push_back(accept_cyc + lat);
        exp_en_q.push_back(en);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_req(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 0, 1);
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        push_exp(op, a, b, cyc + 1);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("drain_timeout", n, (n < 1000) ? n : 0);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("reset_outputs",
              {rsp_valid, rsp_error, rsp_result, alu_enable, alu_op_select,
               alu_operand_1, alu_operand_2, busy}, 64'd0);
        exp_q.delete();
        exp_err_q.delete();
        exp_cyc_q.delete();
        exp_en_q.delete();
        ref_phase = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("ready_after_reset", {req_ready, busy}, 2'b10);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic         prev_valid = 1'b0;
    int           en_cnt = 0;
    logic [W-1:0] hold_res;
    logic         hold_err;
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_valid = 1'b0;
            en_cnt     = 0;
        end else begin
            if (alu_enable) en_cnt++;
            if (rsp_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    check("rsp_result", rsp_result, exp_q.pop_front());
                    check("rsp_error", rsp_error, exp_err_q.pop_front());
                    check("rsp_latency", cyc, exp_cyc_q.pop_front());
                    check("alu_enable_cycles", en_cnt, exp_en_q.pop_front());
                end
                en_cnt   = 0;
                hold_res = rsp_result;
                hold_err = rsp_error;
            end else if (rsp_valid) begin
                check("stall_hold", {rsp_result, rsp_error, req_ready, alu_enable},
                      {hold_res, hold_err, 1'b0, 1'b0});
            end
            prev_valid = rsp_valid;
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #2 bp_rand = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        #1 reset_n = 1'b0;
        apply_reset();

        do_req(OP_ADD, 16'h0003, 16'h0004);
        drain();

        apply_reset();
        do_req(OP_MUL, 16'h0005, 16'hFFFD);
        drain();

        apply_reset();
        do_req(OP_SUB, 16'h0009, 16'h0004);
        do_req(OP_SUB, 16'h0000, 16'h0001);
        do_req(OP_MUL, 16'h0007, 16'h0006);
        drain();

        do_req(OP_RSV, 16'hABCD, 16'h1234);
        do_req(OP_ADD, 16'h00FF, 16'h0001);
        drain();

        // backpressure: response held 10 cycles, queued request waits for the handshake
        rdy_hold = 1'b0;
        do_req(OP_ADD, 16'h1234, 16'h0101);
        begin
            int n;
            n = 0;
            while (!rsp_valid && n < 50) begin
                @(negedge clock);
                n++;
            end
            check("bp_rsp_seen", rsp_valid, 1);
        end
        req_valid = 1'b1;
        req_op    = OP_SUB;
        req_a     = 16'h0010;
        req_b     = 16'h0003;
        repeat (10) @(negedge clock);
        rdy_hold = 1'b1;
        push_exp(OP_SUB, 16'h0010, 16'h0003, cyc + 2);
        @(negedge clock);
        check("ready_after_handshake", {req_ready, rsp_valid}, 2'b10);
        @(negedge clock);
        req_valid = 1'b0;
        drain();

        // phase wrap boundaries: 17 steps leave one align cycle, 18 wrap to zero
        apply_reset();
        for (int i = 0; i < 17; i++) do_req(OP_ADD, W'($urandom), W'($urandom));
        do_req(OP_MUL, W'($urandom), W'($urandom));
        for (int i = 0; i < 18; i++) do_req(OP_SUB, W'($urandom), W'($urandom));
        do_req(OP_MUL, W'($urandom), W'($urandom));
        drain();

        // randomised traffic with random response backpressure
        bp_mode = 1'b1;
        for (int i = 0; i < 60; i++) begin
            do_req(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
        end
        drain();
        bp_mode = 1'b0;

        // reset during the 7th EXEC cycle of a multiply aborts it silently
        apply_reset();
        do_req(OP_MUL, 16'h1111, 16'h0003);
        repeat (6) @(negedge clock);
        check("busy_before_abort", {busy, alu_enable, alu_op_select}, {1'b1, 1'b1, OP_MUL});
        apply_reset();
        repeat (30) @(negedge clock);
        do_req(OP_ADD, 16'h0002, 16'h0002);
        do_req(OP_MUL, 16'h0100, 16'h0003);
        drain();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Front-end controller for the 16-bit shift-add/Booth ALU. Accepts one operation at a time over a valid/ready request channel and drives the ALU's operand, enable and op-select inputs.
- Tracks the ALU's internal 18-state step counter with a shadow phase counter, so every multiply starts at phase 0.
- Returns the 16-bit result over a valid/ready response channel with backpressure.
- Sits between the instruction/control path and the ALU instance.

Parameters:
- WIDTH, 16, operand and result width.
- MULT_CYCLES, 18, enabled ALU cycles per multiply. Also the ALU phase modulus.
- PHASE_W, 5, width of the shadow phase counter. Must satisfy 2^PHASE_W >= MULT_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready. High only in IDLE.
- req_op  in  2  operation code: 00 add, 01 sub, 10 mult, 11 reserved.
- req_a  in  WIDTH  operand 1.
- req_b  in  WIDTH  operand 2.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_result  out  WIDTH  result.
- rsp_error  out  1  high when the request used the reserved op code.
- busy  out  1  high whenever state is not IDLE.
- alu_operand_1  out  WIDTH  to ALU Operand_1.
- alu_operand_2  out  WIDTH  to ALU Operand_2.
- alu_enable  out  1  to ALU enable_ALU.
- alu_op_select  out  2  to ALU op_select.
- alu_result  in  WIDTH  from ALU result register.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values:
  - state = IDLE, phase = 0, step counter = 0.
  - rsp_valid = 0, rsp_error = 0, rsp_result = 0.
  - alu_enable = 0, alu_op_select = 00, alu_operand_1 = 0, alu_operand_2 = 0.
  - req_ready = 1 once reset is released.
- Reset mid-operation aborts the operation with no response. The ALU counter must itself be 0 at reset release; guaranteeing that is a system-level requirement outside this block.
- Request capture: on req_valid & req_ready, latch op, a and b into internal registers.
- Shadow phase:
  - Increments on every cycle in which alu_enable = 1.
  - Wraps MULT_CYCLES-1 -> 0.
  - Never changes while alu_enable = 0.
- States:
  - IDLE: alu_enable = 0, req_ready = 1. On accept:
    - op 11 -> RESP, with rsp_error = 1 and rsp_result = 0. No ALU cycles are issued.
    - op 0x -> EXEC, step count 1.
    - op 10 and phase = 0 -> EXEC, step count MULT_CYCLES.
    - op 10 and phase != 0 -> ALIGN.
  - ALIGN:
    - alu_enable = 1, alu_op_select = 00, operands = 0.
    - Lasts (MULT_CYCLES - phase) cycles, then goes to EXEC with step count MULT_CYCLES.
  - EXEC:
    - alu_enable = 1, alu_op_select = latched op, operands = latched a and b.
    - Decrement the step count each cycle. When it reaches 0, go to CAPTURE.
  - CAPTURE:
    - alu_enable = 0.
    - rsp_result <= alu_result, rsp_valid <= 1, rsp_error <= 0. Go to RESP.
  - RESP:
    - Hold rsp_valid and the response data stable until rsp_ready.
    - On rsp_valid & rsp_ready, clear rsp_valid and go to IDLE.
- A new request is accepted no earlier than the cycle after the response handshake. This is a single-outstanding design.
- Latency, counted from the request-accept edge to rsp_valid high:
  - add/sub: 3 cycles.
  - mult at phase 0: MULT_CYCLES + 2 = 20 cycles.
  - mult at phase p != 0: 20 + (18 - p) cycles.
- Phase after operations:
  - add/sub advances phase by 1.
  - mult leaves phase at 0.
  - op 11 leaves phase unchanged.
- rsp_ready held high continuously gives zero extra stall. rsp_ready held low stalls indefinitely with no ALU activity.

Decomposition:
- Shared package alu_pkg holds:
  - the op-code localparams: OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_RSV = 2'b11;
  - the state encoding IDLE, ALIGN, EXEC, CAPTURE, RESP;
  - MULT_CYCLES.
- One sub-module is natural: alu_phase_tracker, a modulo-MULT_CYCLES counter with an enable input, a phase output and a "cycles-to-zero" output.

Test Plan:
- Reset, then add with a = 0x0003, b = 0x0004 -> alu_enable high exactly 1 cycle with op 00; rsp_result = 0x0007 at accept + 3; phase = 1.
- After reset, mult with a = 0x0005, b = 0xFFFD (-3) -> 0 ALIGN cycles, 18 EXEC cycles; rsp_result = 0xFFF1; phase = 0.
- Two subs (9 - 4 = 5, then 0 - 1 = 0xFFFF), then mult 0x0007 × 0x0006 -> 16 ALIGN cycles with op 00, then 18 EXEC cycles; rsp_result = 0x002A; latency 36 cycles.
- Op 11 with any operands -> alu_enable never asserted; rsp_error = 1; rsp_result = 0; phase unchanged.
- Hold rsp_ready = 0 for 10 cycles after rsp_valid -> rsp_result stable, req_ready = 0, alu_enable = 0; a new req_valid is not accepted until 1 cycle after the handshake.
- Assert reset_n low at EXEC step 7 of a mult -> all outputs return to reset values asynchronously; phase = 0; no response issued.
